// File: rtl/layer_maxpool_if.sv
// Pixel stream bundle for the 2x2 max-pool layer.
// Master drives pixels in, slave returns pooled pixels.
interface layer_maxpool_if #(
    parameter int CHANNELS = 16,
    parameter int BIT_DATA = 8
);
    logic                         valid_in;
    logic [CHANNELS*BIT_DATA-1:0] x;
    logic                         valid_out;
    logic [CHANNELS*BIT_DATA-1:0] y;
    logic                         frame_done;

    modport master (
        output valid_in, x,
        input  valid_out, y, frame_done
    );

    modport slave (
        input  valid_in, x,
        output valid_out, y, frame_done
    );
endinterface

// File: rtl/layer_maxpool.sv
// Streaming 2x2 stride-2 signed max-pool over a raster pixel stream.
// Even rows fold pairs into a half-width row buffer; odd rows finish the window.
module layer_maxpool #(
    parameter int CHANNELS = 16,
    parameter int BIT_DATA = 8,
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    layer_maxpool_if.slave  bus
);
    localparam int PW   = CHANNELS * BIT_DATA;
    localparam int HALF = WIDTH / 2;
    localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic {EVEN_ROW, ODD_ROW} phase_t;

    phase_t        phase;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] hold;
    logic [PW-1:0] rowbuf [HALF];
    logic [PW-1:0] y_q;
    logic          vout_q;
    logic          fdone_q;

    logic [BW-1:0] bidx;
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] pair_max;
    logic [PW-1:0] quad_max;
    logic          last_col;
    logic          last_row;

    assign bidx     = BW'(col >> 1);
    assign buf_rd   = rowbuf[bidx];
    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [BIT_DATA-1:0] hv;
        logic signed [BIT_DATA-1:0] xv;
        logic signed [BIT_DATA-1:0] bv;
        logic signed [BIT_DATA-1:0] pv;
        assign hv = hold[c*BIT_DATA +: BIT_DATA];
        assign xv = bus.x[c*BIT_DATA +: BIT_DATA];
        assign bv = buf_rd[c*BIT_DATA +: BIT_DATA];
        assign pv = (hv > xv) ? hv : xv;
        assign pair_max[c*BIT_DATA +: BIT_DATA] = pv;
        assign quad_max[c*BIT_DATA +: BIT_DATA] = (bv > pv) ? bv : pv;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase   <= EVEN_ROW;
            col     <= '0;
            row     <= '0;
            hold    <= '0;
            y_q     <= '0;
            vout_q  <= 1'b0;
            fdone_q <= 1'b0;
            for (int i = 0; i < HALF; i++) rowbuf[i] <= '0;
        end else begin
            vout_q  <= 1'b0;
            fdone_q <= 1'b0;
            if (flush) begin
                phase <= EVEN_ROW;
                col   <= '0;
                row   <= '0;
                hold  <= '0;
            end else if (bus.valid_in) begin
                if (!col[0]) begin
                    hold <= bus.x;
                end else if (phase == EVEN_ROW) begin
                    rowbuf[bidx] <= pair_max;
                end else begin
                    y_q     <= quad_max;
                    vout_q  <= 1'b1;
                    fdone_q <= last_row && last_col;
                end
                // Row parity tracks phase; HEIGHT is even so a frame wrap lands on EVEN_ROW.
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row   <= '0;
                        phase <= EVEN_ROW;
                    end else begin
                        row   <= row + 1'b1;
                        phase <= (phase == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign bus.y          = y_q;
    assign bus.valid_out  = vout_q;
    assign bus.frame_done = fdone_q;
endmodule

// File: tb/tb_layer_maxpool.sv
// Bench for layer_maxpool: directed scenarios plus random frames,
// checked against a frame-array reference of 2x2 window maxima.
module tb_layer_maxpool;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int C  = 2;
    localparam int B  = 8;
    localparam int PW = C * B;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    layer_maxpool_if #(.CHANNELS(C), .BIT_DATA(B)) bus ();

    layer_maxpool #(
        .CHANNELS(C), .BIT_DATA(B), .WIDTH(W), .HEIGHT(H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [PW-1:0] fr [H][W];
    int            mr = 0;
    int            mc = 0;
    logic          exp_v  = 1'b0;
    logic          exp_fd = 1'b0;
    logic [PW-1:0] exp_y  = '0;
    int            outs0[$];
    int            eq[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pool(int r, int c);
        logic [PW-1:0]       res;
        logic signed [B-1:0] m;
        logic signed [B-1:0] v;
        res = '0;
        for (int ch = 0; ch < C; ch++) begin
            m = fr[r][c][ch*B +: B];
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    v = fr[r-dr][c-dc][ch*B +: B];
                    if (v > m) m = v;
                end
            res[ch*B +: B] = m;
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] ramp(int r, int c);
        logic signed [B-1:0] a;
        logic signed [B-1:0] b;
        a = B'(r * W + c);
        b = B'(-(r * W + c));
        return {b, a};
    endfunction

    task automatic step(bit v, logic [PW-1:0] p, bit fl);
        bus.valid_in = v;
        bus.x        = p;
        flush        = fl;
        exp_v        = 1'b0;
        exp_fd       = 1'b0;
        if (fl) begin
            mr = 0;
            mc = 0;
        end else if (v) begin
            fr[mr][mc] = p;
            if (mr % 2 == 1 && mc % 2 == 1) begin
                exp_v  = 1'b1;
                exp_y  = pool(mr, mc);
                exp_fd = (mr == H - 1 && mc == W - 1);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr + 1) % H;
            end
        end
        @(posedge clock);
        #1;
        check("valid_out", 32'(bus.valid_out), 32'(exp_v));
        check("y", 32'(bus.y), 32'(exp_y));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        if (bus.valid_out) outs0.push_back(int'($signed(bus.y[B-1:0])));
        if (bus.frame_done) fd_cnt++;
    endtask

    task automatic cmp_list(string tag, int e[$]);
        check({tag, "_count"}, 32'(outs0.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (i < outs0.size())
                check({tag, "_val"}, 32'(outs0[i]), 32'(e[i]));
    endtask

    task automatic ramp_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                step(1'b1, ramp(r, c), 1'b0);
    endtask

    task automatic async_reset();
        bus.valid_in = 1'b0;
        flush        = 1'b0;
        #2;
        reset = 1'b0;
        mr    = 0;
        mc    = 0;
        exp_y = '0;
        #1;
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.x        = '0;
        #12;
        check("reset_y", 32'(bus.y), 32'd0);
        check("reset_valid_out", 32'(bus.valid_out), 32'd0);
        check("reset_frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        outs0.delete();
        fd_cnt = 0;
        ramp_frame();
        eq = {5, 7, 13, 15};
        cmp_list("ramp", eq);
        check("ramp_fd", 32'(fd_cnt), 32'd1);

        outs0.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                step(1'b1, (r == 2 && c == 3) ? 16'hffff : 16'h8080, 1'b0);
        eq = {-128, -128, -128, -1};
        cmp_list("signed", eq);

        outs0.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                step(1'b1, ramp(r, c), 1'b0);
                step(1'b0, PW'($urandom), 1'b0);
            end
        eq = {5, 7, 13, 15};
        cmp_list("bubble", eq);

        for (int i = 0; i < 6; i++) step(1'b1, PW'($urandom), 1'b0);
        step(1'b1, PW'($urandom), 1'b1);
        outs0.delete();
        ramp_frame();
        eq = {5, 7, 13, 15};
        cmp_list("flush", eq);

        for (int i = 0; i < 10; i++) step(1'b1, ramp(i / W, i % W), 1'b0);
        async_reset();
        outs0.delete();
        ramp_frame();
        eq = {5, 7, 13, 15};
        cmp_list("midreset", eq);

        outs0.delete();
        fd_cnt = 0;
        ramp_frame();
        ramp_frame();
        eq = {5, 7, 13, 15, 5, 7, 13, 15};
        cmp_list("b2b", eq);
        check("b2b_fd", 32'(fd_cnt), 32'd2);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, PW'($urandom),
                 $urandom_range(0, 60) == 0);
        step(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer_maxpool.md
LAYER_MAXPOOL -- requirements
Module: layer_maxpool

Interface
- REQ-001 SHALL have parameter CHANNELS, default 16, number of channels carried per pixel (equals FILTER_OUT of the feeding convolution layer).
- REQ-002 SHALL have parameter BIT_DATA, default 8, signed width of one channel value.
- REQ-003 SHALL have parameter WIDTH, default 8, input feature-map width in pixels; even and at least 2.
- REQ-004 SHALL have parameter HEIGHT, default 8, input feature-map height in pixels; even and at least 2.
- REQ-005 SHALL have port clock  input  1  the single clock; all state updates on the rising edge.
- REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 clears state immediately.
- REQ-007 SHALL have port flush  input  1  synchronous frame restart.
- REQ-008 SHALL have port valid_in  input  1  qualifies x for this cycle.
- REQ-009 SHALL have port x  input  CHANNELS*BIT_DATA  one pixel, raster order; channel c at bits [BIT_DATA*(c+1)-1 : BIT_DATA*c], signed.
- REQ-010 SHALL have port valid_out  output  1  qualifies y.
- REQ-011 SHALL have port y  output  CHANNELS*BIT_DATA  pooled pixel; same channel packing as x.
- REQ-012 SHALL have port frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Function
- REQ-013 SHALL perform 2x2 max-pooling with stride 2, independently per channel, using signed comparison.
- REQ-014 SHALL keep a column counter (0..WIDTH-1) and a row counter (0..HEIGHT-1) that advance only on cycles with valid_in=1; valid_in=0 cycles hold all state (bubbles allowed anywhere).
- REQ-015 SHALL wrap the column counter to 0 after WIDTH-1 and increment the row counter; SHALL wrap the row counter to 0 after HEIGHT-1, so the next pixel starts a new frame.
- REQ-016 SHALL operate in two phases selected by row parity: EVEN_ROW and ODD_ROW.
- REQ-017 EVEN_ROW: on an even column SHALL register x in a hold register; on an odd column SHALL write max(hold, x) into row-buffer entry col/2 (WIDTH/2 entries of CHANNELS*BIT_DATA).
- REQ-018 ODD_ROW: on an even column SHALL register x in hold; on an odd column SHALL compute max(rowbuf[col/2], hold, x) per channel.
- REQ-019 SHALL register that result onto y with valid_out=1 on the cycle after the odd-row, odd-column input is accepted (latency 1); valid_out=0 on all other cycles.
- REQ-020 SHALL hold y at its last value while valid_out=0.
- REQ-021 SHALL produce exactly (WIDTH/2)*(HEIGHT/2) outputs per frame, in raster order of the pooled map.
- REQ-022 SHALL assert frame_done together with valid_out for the output generated by input (HEIGHT-1, WIDTH-1).
- REQ-023 flush=1 SHALL zero both counters and the hold register on the next edge; valid_out and frame_done SHALL be 0 on that edge; row-buffer contents need not be cleared.
- REQ-024 flush=1 with valid_in=1 in the same cycle: flush SHALL win and the pixel SHALL be discarded.
- REQ-025 A complete frame followed immediately by the next frame (continuous valid_in) SHALL need no idle cycle.

Reset
- REQ-026 While reset=0, counters, hold register and row buffer SHALL be 0; y SHALL be 0; valid_out=0; frame_done=0.
- REQ-027 Reset asserted mid-frame SHALL abandon the partial frame; the first valid pixel after release SHALL be treated as (row 0, col 0).

Verification (WIDTH=4, HEIGHT=4, CHANNELS=2, BIT_DATA=8 unless stated)
- REQ-028 Ramp: channel 0 = row*4+col, channel 1 = -(row*4+col), continuous valid_in -> channel 0 outputs 5, 7, 13, 15; channel 1 outputs 0, -2, -8, -10; each output 1 cycle after input (1,1), (1,3), (3,1), (3,3); frame_done only with 15.
- REQ-029 Signedness: all pixels -128 except (2,3) = -1 -> outputs -128, -128, -128, -1 (catches unsigned compare).
- REQ-030 Bubbles: ramp of REQ-028 with valid_in alternating 1/0 -> identical output values and order; valid_out 1 cycle after each accepted qualifying input.
- REQ-031 Flush: 6 pixels then flush=1 together with valid_in=1, then a full ramp frame -> no output from the partial frame; exactly 4 outputs 5, 7, 13, 15.
- REQ-032 Reset mid-frame: reset=0 after 10 pixels -> y=0, valid_out=0 immediately; after release, full ramp -> 5, 7, 13, 15.
- REQ-033 Back-to-back: two ramp frames with no gap -> 8 outputs 5, 7, 13, 15, 5, 7, 13, 15; two frame_done pulses.
